// File: rtl/alu_pkg.sv
// Shared encodings for the button-driven operand entry path.
// Phase and op encodings match the display driver and alu3.
package alu_pkg;

    localparam int W_OP = 3;

    typedef enum logic [1:0] {
        PH_EDIT_A  = 2'b00,
        PH_EDIT_B  = 2'b01,
        PH_EDIT_OP = 2'b10,
        PH_SHOW    = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_NEXT,
        ACT_BACK,
        ACT_UP,
        ACT_DOWN
    } act_t;

    function automatic int db_count(input int clk_hz, input int ms);
        int c;
        c = clk_hz / 1000 * ms;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF sync, stability debounce, press pulse.
// Optional hold-to-repeat under BTN_AUTO_REPEAT_EN.
module btn_debounce #(
    parameter int DB_CYCLES = 1
`ifdef BTN_AUTO_REPEAT_EN
    ,
    parameter int CLK_HZ = 1000,
    parameter bit REPEAT = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic          edge_pulse;
    logic          rep_pulse;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            edge_pulse <= 1'b0;
        end else begin
            s1         <= raw;
            s2         <= s1;
            edge_pulse <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level      <= s2;
                cnt        <= '0;
                edge_pulse <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    generate
        if (REPEAT) begin : g_rep
            localparam int REP_FIRST = CLK_HZ / 1000 * 500;
            localparam int REP_NEXT  = CLK_HZ / 1000 * 100;

            logic [31:0] rcnt;
            logic        first;

            // Hold timer restarts whenever the accepted level drops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rcnt      <= '0;
                    first     <= 1'b1;
                    rep_pulse <= 1'b0;
                end else if (!level) begin
                    rcnt      <= '0;
                    first     <= 1'b1;
                    rep_pulse <= 1'b0;
                end else begin
                    rep_pulse <= 1'b0;
                    if (rcnt == (first ? 32'(REP_FIRST - 1)
                                       : 32'(REP_NEXT - 1))) begin
                        rep_pulse <= 1'b1;
                        rcnt      <= '0;
                        first     <= 1'b0;
                    end else begin
                        rcnt <= rcnt + 32'd1;
                    end
                end
            end
        end else begin : g_norep
            assign rep_pulse = 1'b0;
        end
    endgenerate
`else
    assign rep_pulse = 1'b0;
`endif

    assign pulse = edge_pulse | rep_pulse;

endmodule

// File: rtl/btn_operand_entry.sv
// Push-button operand/op entry feeding alu3; optional auto-repeat
// on up/down when BTN_AUTO_REPEAT_EN is defined.
module btn_operand_entry
    import alu_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            btn_next,
    input  logic            btn_back,
    output logic [W_OP-1:0] A,
    output logic [W_OP-1:0] B,
    output logic [1:0]      op,
    output logic            sub_dir,
    output logic [1:0]      phase,
    output logic            result_valid
);

    localparam int DB_CYCLES = db_count(CLK_HZ, DEBOUNCE_MS);

    logic [3:0] raw;
    logic [3:0] pulse;

    // Bit order: next, back, up, down.
    assign raw = {btn_down, btn_up, btn_back, btn_next};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
            ,
            .CLK_HZ(CLK_HZ),
            .REPEAT(i >= 2)
`endif
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .pulse(pulse[i])
        );
    end

    phase_t          phase_q, phase_n;
    logic [W_OP-1:0] a_q, a_n;
    logic [W_OP-1:0] b_q, b_n;
    op_t             op_q, op_n;
    logic            dir_q, dir_n;
    logic            rv_q;
    act_t            act;

    always_comb begin
        act = ACT_NONE;
        if (pulse[0])      act = ACT_NEXT;
        else if (pulse[1]) act = ACT_BACK;
        else if (pulse[2]) act = ACT_UP;
        else if (pulse[3]) act = ACT_DOWN;
    end

    always_comb begin
        phase_n = phase_q;
        a_n     = a_q;
        b_n     = b_q;
        op_n    = op_q;
        dir_n   = dir_q;
        unique case (act)
            ACT_NEXT: begin
                unique case (phase_q)
                    PH_EDIT_A:  phase_n = PH_EDIT_B;
                    PH_EDIT_B:  phase_n = PH_EDIT_OP;
                    PH_EDIT_OP: phase_n = PH_SHOW;
                    PH_SHOW:    phase_n = PH_EDIT_A;
                endcase
            end
            ACT_BACK: begin
                unique case (phase_q)
                    PH_SHOW:    phase_n = PH_EDIT_OP;
                    PH_EDIT_OP: phase_n = PH_EDIT_B;
                    default:    phase_n = PH_EDIT_A;
                endcase
            end
            ACT_UP: begin
                unique case (phase_q)
                    PH_EDIT_A:  a_n = a_q + W_OP'(1);
                    PH_EDIT_B:  b_n = b_q + W_OP'(1);
                    PH_EDIT_OP: begin
                        unique case (op_q)
                            OP_ADD:  op_n = OP_SUB;
                            OP_SUB:  op_n = OP_MUL;
                            default: op_n = OP_ADD;
                        endcase
                    end
                    PH_SHOW:    dir_n = ~dir_q;
                endcase
            end
            ACT_DOWN: begin
                unique case (phase_q)
                    PH_EDIT_A:  a_n = a_q - W_OP'(1);
                    PH_EDIT_B:  b_n = b_q - W_OP'(1);
                    PH_EDIT_OP: begin
                        unique case (op_q)
                            OP_ADD:  op_n = OP_MUL;
                            OP_MUL:  op_n = OP_SUB;
                            default: op_n = OP_ADD;
                        endcase
                    end
                    PH_SHOW:    dir_n = ~dir_q;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_EDIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            dir_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            phase_q <= phase_n;
            a_q     <= a_n;
            b_q     <= b_n;
            op_q    <= op_n;
            dir_q   <= dir_n;
            rv_q    <= (phase_n == PH_SHOW);
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign op           = op_q;
    assign sub_dir      = dir_q;
    assign phase        = phase_q;
    assign result_valid = rv_q;

endmodule
